word_fetch_ctrl: RTL and testbench

- Sequencer that builds one 16-bit word from two 8-bit memory reads for the 8-bit datapath of the 3-stage processor.
- On a request it reads the low byte at address A, then the high byte at A+1 (little-endian).
- It merges the two bytes through the joiner sub-module and holds the 16-bit result under a valid/ack handshake.
- It sits between the fetch/decode stage and the byte-wide instruction/data memory, and supports a pipeline flush.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/word_fetch_ctrl_joiner.sv | 8 +
 rtl/word_fetch_ctrl.sv | 79 +++++++
 tb/tb_word_fetch_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding and latency constants shared by the word fetch controller
package fetch_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_LO   = 3'd1,
        WAIT_LO = 3'd2,
        RD_HI   = 3'd3,
        WAIT_HI = 3'd4,
        DONE    = 3'd5
    } state_t;
    localparam int MEM_LAT_DEF = 1;
    localparam int WAIT_W_DEF = $clog2(MEM_LAT_DEF + 1);
    function automatic int wait_w(input int lat);
        return $clog2(lat + 1);
    endfunction
endpackage

// File: rtl/word_fetch_ctrl_joiner.sv
// joiner: merges a low and a high byte into one little-endian 16-bit word
module joiner (
    input  logic [7:0]  low,
    input  logic [7:0]  high,
    output logic [15:0] o
);
    assign o = {high, low};
endmodule

// File: rtl/word_fetch_ctrl.sv
// word_fetch_ctrl: builds a 16-bit word from two byte reads at A and A+1 with valid/ack hand-off
module word_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              ready,
    input  logic              flush,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [15:0]       word,
    output logic              word_valid,
    input  logic              word_ack,
    output logic              busy,
    output logic [CNT_W-1:0]  fetch_cnt
);
    localparam int WW = wait_w(MEM_LAT);
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr, r_mem_addr, w_addr_hi;
    logic [7:0]        r_lo, r_hi;
    logic [WW-1:0]     r_wcnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [15:0]       w_join;
    logic              w_last;

    joiner u_joiner (.low(r_lo), .high(r_hi), .o(w_join));

    assign w_addr_hi  = r_addr + ADDR_W'(1);
    assign w_last     = r_wcnt == WW'(1);
    assign ready      = r_state == IDLE && !flush;
    assign busy       = r_state != IDLE;
    assign mem_rd_en  = r_state == RD_LO || r_state == RD_HI;
    assign mem_addr   = r_state == RD_LO ? r_addr : r_state == RD_HI ? w_addr_hi : r_mem_addr;
    assign word_valid = r_state == DONE;
    assign word       = word_valid ? w_join : 16'h0;
    assign fetch_cnt  = r_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = req && ready ? RD_LO : IDLE;
            RD_LO:   w_next = WAIT_LO;
            WAIT_LO: w_next = w_last ? RD_HI : WAIT_LO;
            RD_HI:   w_next = WAIT_HI;
            WAIT_HI: w_next = w_last ? DONE : WAIT_HI;
            DONE:    w_next = word_ack ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    // the wait counter reloads on every read strobe and the byte is taken only on its final count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_mem_addr <= '0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_wcnt     <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req && ready) r_addr <= req_addr;
            if (mem_rd_en) r_mem_addr <= mem_addr;
            r_wcnt <= mem_rd_en ? WW'(MEM_LAT) : r_wcnt - WW'(r_wcnt != '0);
            if (!flush && r_state == WAIT_LO && w_last) r_lo <= mem_rdata;
            if (!flush && r_state == WAIT_HI && w_last) r_hi <= mem_rdata;
            if (!flush && r_state == DONE && word_ack) r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_word_fetch_ctrl.sv
// tb_word_fetch_ctrl: directed vectors for word_fetch_ctrl at MEM_LAT=1 and MEM_LAT=3
module tb_word_fetch_ctrl;
    logic        clk = 0;
    always #5 clk = ~clk;
    logic        rst, req, flush, word_ack, mem_rd_en, word_valid, busy, ready;
    logic [7:0]  req_addr, mem_addr, mem_rdata;
    logic [15:0] word, fetch_cnt;
    logic        req3, ack3, rd3, valid3, busy3, ready3;
    logic [7:0]  addr3, a3, rdata3;
    logic [15:0] word3, cnt3;
    logic [7:0]  mem [256];
    int          n_vec = 0, n_bad = 0;
    logic [15:0] exp_cnt = 0;

    word_fetch_ctrl #(.ADDR_W(8), .MEM_LAT(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .ready(ready), .flush(flush),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .word(word),
        .word_valid(word_valid), .word_ack(word_ack), .busy(busy), .fetch_cnt(fetch_cnt));

    word_fetch_ctrl #(.ADDR_W(8), .MEM_LAT(3), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst), .req(req3), .req_addr(addr3), .ready(ready3), .flush(1'b0),
        .mem_rd_en(rd3), .mem_addr(a3), .mem_rdata(rdata3), .word(word3),
        .word_valid(valid3), .word_ack(ack3), .busy(busy3), .fetch_cnt(cnt3));

    // byte memories drive 0xEE whenever their data is not due, so early capture shows up
    logic       v1 = 0;
    logic [7:0] d1;
    always @(posedge clk) begin
        v1 <= mem_rd_en;
        d1 <= mem[mem_addr];
    end
    assign mem_rdata = v1 ? d1 : 8'hEE;
    logic [2:0] v3 = '0;
    logic [7:0] d3 [3];
    always @(posedge clk) begin
        v3 <= {v3[1:0], rd3};
        d3[0] <= mem[a3];
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign rdata3 = v3[2] ? d3[2] : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
    endtask

    task automatic fetch(input logic [7:0] a, input logic [15:0] exp, input int hold);
        int         k;
        logic [7:0] a2, ah;
        logic       ok;
        ah = a + 8'd1;
        nc(); req = 1; req_addr = a;
        k = 0; a2 = 0;
        do begin
            nc(); req = 0; #1; k++;
            if (mem_rd_en) a2 = mem_addr;
        end while (!word_valid && k < 20);
        chk("latency", k, 5);
        chk("hi_addr", a2, ah);
        chk("word", word, exp);
        ok = 1;
        for (int i = 0; i < hold; i++) begin
            nc(); req = i[0]; req_addr = 8'h50; #1;
            ok &= word_valid && word == exp && !ready && fetch_cnt == exp_cnt;
        end
        if (hold > 0) chk("hold", ok, 1);
        nc(); req = 0; word_ack = 1; #1;
        nc(); word_ack = 0; #1;
        exp_cnt++;
        chk("cnt", fetch_cnt, exp_cnt);
        chk("idle", {busy, ready, word_valid}, 3'b010);
    endtask

    initial begin
        int  k;
        logic ok;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h10] = 8'h34; mem[8'h11] = 8'h12;
        mem[8'hFF] = 8'hCD; mem[8'h00] = 8'hAB;
        mem[8'h20] = 8'hEF; mem[8'h21] = 8'hBE;
        mem[8'h40] = 8'h11; mem[8'h41] = 8'h22;
        rst = 1; req = 0; flush = 0; word_ack = 0; req_addr = 0;
        req3 = 0; ack3 = 0; addr3 = 0;
        nc(); nc(); rst = 0; #1;
        chk("rst_out", {mem_rd_en, mem_addr, word, word_valid, busy}, 0);
        chk("rst_cnt", fetch_cnt, 0);
        chk("rst_ready", ready, 1);
        // basic fetch, cycle by cycle
        nc(); req = 1; req_addr = 8'h10; #1;
        chk("c0_ready", ready, 1);
        nc(); req = 0; #1;
        chk("c1_rd", {mem_rd_en, mem_addr, busy, ready}, {1'b1, 8'h10, 1'b1, 1'b0});
        nc(); #1;
        chk("c2_rd", {mem_rd_en, mem_addr}, {1'b0, 8'h10});
        nc(); #1;
        chk("c3_rd", {mem_rd_en, mem_addr}, {1'b1, 8'h11});
        nc(); #1;
        chk("c4_valid", {mem_rd_en, word_valid}, 2'b00);
        nc(); #1;
        chk("c5_word", {word_valid, word}, {1'b1, 16'h1234});
        word_ack = 1;
        nc(); word_ack = 0; #1;
        exp_cnt = 1;
        chk("c6_cnt", fetch_cnt, 1);
        chk("c6_idle", {ready, word_valid, busy}, 3'b100);
        // address wrap and backpressure
        fetch(8'hFF, 16'hABCD, 0);
        fetch(8'h30, 16'h6B6A, 10);
        // flush with req in IDLE
        nc(); req = 1; flush = 1; req_addr = 8'h10; #1;
        chk("fl_ready", ready, 0);
        nc(); req = 0; flush = 0; #1;
        chk("fl_noread", {mem_rd_en, busy}, 2'b00);
        // flush in WAIT_HI
        nc(); req = 1; req_addr = 8'h60;
        nc(); req = 0;
        nc(); nc();
        nc(); flush = 1; #1;
        chk("fl_whi", {busy, mem_rd_en}, 2'b10);
        nc(); flush = 0; #1;
        chk("fl_after", {busy, word_valid, word}, 0);
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            nc(); #1;
            ok &= !word_valid;
        end
        chk("fl_novalid", ok, 1);
        chk("fl_cnt", fetch_cnt, exp_cnt);
        // reset in RD_HI
        nc(); req = 1; req_addr = 8'h70;
        nc(); req = 0;
        nc();
        nc(); rst = 1; #1;
        chk("rs_rdhi", {mem_rd_en, mem_addr}, {1'b1, 8'h71});
        nc(); rst = 0; #1;
        chk("rs_out", {mem_rd_en, mem_addr, word, word_valid, busy, ready}, 1);
        chk("rs_cnt", fetch_cnt, 0);
        exp_cnt = 0;
        fetch(8'h20, 16'hBEEF, 0);
        // MEM_LAT=3 instance
        nc(); req3 = 1; addr3 = 8'h40;
        k = 0;
        do begin
            nc(); req3 = 0; #1; k++;
        end while (!valid3 && k < 20);
        chk("l3_latency", k, 9);
        chk("l3_word", word3, 16'h2211);
        nc(); ack3 = 1;
        nc(); ack3 = 0; #1;
        chk("l3_cnt", {cnt3, valid3, ready3}, {16'd1, 1'b0, 1'b1});
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
